// File: rtl/async_ram_pkg.sv
// Shared types and defaults for the asynchronous RAM controller.
// Also holds the helper that sizes the phase counter.
package async_ram_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        INIT
    } ctrl_state_t;

    typedef enum logic {
        OP_RD,
        OP_WR
    } ram_op_t;

    function automatic int max_cycles(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/async_ram_phase_cnt.sv
// Loadable down-counter that times one FSM phase.
// last is high while the count sits at 1, i.e. during the final cycle of the phase.
module async_ram_phase_cnt #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         last_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign last_o = (cnt_q == W'(1));

endmodule

// File: rtl/async_ram_ctrl.sv
// Clocked initiator for a 64K x 8 asynchronous RAM: sequences chip_en/strobes/addr/data
// around single-beat requests and issues timed clear pulses on the RAM reset pin.
module async_ram_ctrl
    import async_ram_pkg::*;
#(
    parameter int ADDR_W        = ADDR_W_DEF,
    parameter int DATA_W        = DATA_W_DEF,
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 2,
    parameter int HOLD_CYCLES   = 1,
    parameter int RST_CYCLES    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    input  logic              init_req,
    output logic              init_done,
    output logic              ram_chip_en,
    output logic              ram_wr_en,
    output logic              ram_rd_en,
    output logic              ram_reset,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_data_out
);

    localparam int MAX_CYC = max_cycles(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES, RST_CYCLES);
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    ctrl_state_t       state_q;
    ram_op_t           op_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              init_done_q;
    logic              chip_en_q;
    logic              wr_en_q;
    logic              rd_en_q;
    logic              ram_reset_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;

    logic              cnt_load_d;
    logic [CNT_W-1:0]  cnt_val_d;
    logic              cnt_last;

    assign req_ready = (state_q == IDLE) && !init_req && !reset;

    // Counter is reloaded on every phase entry; init takes priority over a pending request.
    always_comb begin
        cnt_load_d = 1'b0;
        cnt_val_d  = '0;
        unique case (state_q)
            IDLE: begin
                if (init_req) begin
                    cnt_load_d = 1'b1;
                    cnt_val_d  = CNT_W'(RST_CYCLES);
                end else if (req_valid) begin
                    cnt_load_d = 1'b1;
                    cnt_val_d  = CNT_W'(SETUP_CYCLES);
                end
            end
            SETUP: begin
                if (cnt_last) begin
                    cnt_load_d = 1'b1;
                    cnt_val_d  = CNT_W'(STROBE_CYCLES);
                end
            end
            STROBE: begin
                if (cnt_last) begin
                    cnt_load_d = 1'b1;
                    cnt_val_d  = CNT_W'(HOLD_CYCLES);
                end
            end
            default: ;
        endcase
    end

    async_ram_phase_cnt #(
        .W(CNT_W)
    ) u_phase_cnt (
        .clk       (clk),
        .reset     (reset),
        .load_i    (cnt_load_d),
        .load_val_i(cnt_val_d),
        .last_o    (cnt_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= OP_RD;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            init_done_q <= 1'b0;
            chip_en_q   <= 1'b0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            ram_reset_q <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            init_done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (init_req) begin
                        state_q     <= INIT;
                        ram_reset_q <= 1'b1;
                        chip_en_q   <= 1'b0;
                    end else if (req_valid) begin
                        state_q   <= SETUP;
                        op_q      <= req_we ? OP_WR : OP_RD;
                        addr_q    <= req_addr;
                        data_q    <= req_wdata;
                        chip_en_q <= 1'b1;
                    end
                end
                SETUP: begin
                    if (cnt_last) begin
                        state_q <= STROBE;
                        wr_en_q <= (op_q == OP_WR);
                        rd_en_q <= (op_q == OP_RD);
                    end
                end
                STROBE: begin
                    if (cnt_last) begin
                        state_q     <= HOLD;
                        wr_en_q     <= 1'b0;
                        rd_en_q     <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        // chip_en is still high here, so data_out is driven
                        if (op_q == OP_RD) begin
                            rsp_rdata_q <= ram_data_out;
                        end
                    end
                end
                HOLD: begin
                    if (cnt_last) begin
                        state_q   <= IDLE;
                        chip_en_q <= 1'b0;
                    end
                end
                INIT: begin
                    if (cnt_last) begin
                        state_q     <= IDLE;
                        ram_reset_q <= 1'b0;
                        init_done_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign init_done   = init_done_q;
    assign ram_chip_en = chip_en_q;
    assign ram_wr_en   = wr_en_q;
    assign ram_rd_en   = rd_en_q;
    assign ram_reset   = ram_reset_q;
    assign ram_addr    = addr_q;
    assign ram_data_in = data_q;

endmodule

// File: tb/tb_async_ram_ctrl.sv
// Bench for async_ram_ctrl: behavioural async RAM load, vector table of accesses,
// hand-written init/reset/back-to-back sequences and a per-cycle protocol monitor.
module tb_async_ram_ctrl;

    localparam int SETUP_C = 1;
    localparam int HOLD_C  = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        init_req;
    logic        init_done;
    logic        ram_chip_en;
    logic        ram_wr_en;
    logic        ram_rd_en;
    logic        ram_reset;
    logic [15:0] ram_addr;
    logic [7:0]  ram_data_in;
    logic [7:0]  ram_data_out;

    int checks = 0;
    int errors = 0;

    async_ram_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .init_req    (init_req),
        .init_done   (init_done),
        .ram_chip_en (ram_chip_en),
        .ram_wr_en   (ram_wr_en),
        .ram_rd_en   (ram_rd_en),
        .ram_reset   (ram_reset),
        .ram_addr    (ram_addr),
        .ram_data_in (ram_data_in),
        .ram_data_out(ram_data_out)
    );

    always #5 clk = ~clk;

    // Behavioural asynchronous RAM: acts only on strobe/reset rising edges.
    logic [7:0] mem [0:65535];
    logic [7:0] dout_q = 8'h00;

    always @(posedge ram_wr_en or posedge ram_reset) begin
        if (ram_reset) begin
            for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        end else if (ram_chip_en) begin
            mem[ram_addr] = ram_data_in;
        end
    end

    always @(posedge ram_rd_en) begin
        if (ram_chip_en) dout_q = mem[ram_addr];
    end

    assign ram_data_out = ram_chip_en ? dout_q : 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Protocol monitor
    logic        p_ce = 1'b0, p_strobe = 1'b0, seen = 1'b0;
    logic [15:0] p_addr = '0;
    logic [7:0]  p_data = '0;
    int          setup_cnt = 0, hold_cnt = 0;

    always @(negedge clk) begin
        logic strobe;
        if (reset) begin
            p_ce = 1'b0; p_strobe = 1'b0; seen = 1'b0;
            setup_cnt = 0; hold_cnt = 0;
        end else begin
            strobe = ram_rd_en | ram_wr_en;
            if (strobe) chk("strobes_exclusive", {31'd0, ram_rd_en & ram_wr_en}, 32'd0);
            if (ram_chip_en && p_ce) begin
                chk("addr_stable", {16'd0, ram_addr}, {16'd0, p_addr});
                chk("data_stable", {24'd0, ram_data_in}, {24'd0, p_data});
            end
            if (strobe && !p_strobe) begin
                chk("strobe_setup", {31'd0, p_ce && (setup_cnt >= SETUP_C)}, 32'd1);
                seen = 1'b1;
            end
            if (!ram_chip_en && p_ce && seen) chk("chip_en_hold", hold_cnt, HOLD_C);
            if (!ram_chip_en) begin
                setup_cnt = 0; hold_cnt = 0; seen = 1'b0;
            end else if (!strobe && !seen) begin
                setup_cnt++;
            end else if (!strobe && seen) begin
                hold_cnt++;
            end
            p_ce = ram_chip_en; p_strobe = strobe;
            p_addr = ram_addr; p_data = ram_data_in;
        end
    end

    // One complete access from an idle controller; checks latency and read data.
    task automatic do_access(input logic we, input logic [15:0] addr, input logic [7:0] wdata,
                             input logic [7:0] exp_rdata);
        int lat;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        chk("ready_at_accept", {31'd0, req_ready}, 32'd1);
        step();
        req_valid = 1'b0; req_addr = ~addr; req_wdata = ~wdata;
        chk("setup_chip_en", {31'd0, ram_chip_en}, 32'd1);
        chk("setup_addr", {16'd0, ram_addr}, {16'd0, addr});
        chk("setup_strobes", {30'd0, ram_rd_en, ram_wr_en}, 32'd0);
        if (we) chk("setup_wdata", {24'd0, ram_data_in}, {24'd0, wdata});
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            step();
            lat++;
        end
        chk("rsp_latency", lat, 4);
        if (!we) chk("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, exp_rdata});
        step();
        chk("rsp_one_cycle", {31'd0, rsp_valid}, 32'd0);
        chk("idle_chip_en", {31'd0, ram_chip_en}, 32'd0);
        chk("idle_ready", {31'd0, req_ready}, 32'd1);
    endtask

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  exp_rdata;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int n_acc, n_rsp, cyc, wait_cyc;
        int acc_cyc [2];
        logic [7:0] rsp_d [2];

        vecs[0] = '{1'b1, 16'h1234, 8'hA5, 8'h00};
        vecs[1] = '{1'b0, 16'h1234, 8'h00, 8'hA5};
        vecs[2] = '{1'b1, 16'hFFFF, 8'h5A, 8'h00};
        vecs[3] = '{1'b1, 16'h0000, 8'h3C, 8'h00};
        vecs[4] = '{1'b0, 16'hFFFF, 8'h00, 8'h5A};
        vecs[5] = '{1'b0, 16'h0000, 8'h00, 8'h3C};
        vecs[6] = '{1'b1, 16'h00FF, 8'h11, 8'h00};
        vecs[7] = '{1'b0, 16'h00FF, 8'h00, 8'h11};

        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_wdata = '0; init_req = 1'b0;
        step(); step();
        chk("rst_outputs", {ram_chip_en, ram_wr_en, ram_rd_en, ram_reset, rsp_valid, init_done}, 32'd0);
        chk("rst_addr_data", {ram_addr, ram_data_in, rsp_rdata}, 32'd0);
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_ready", {31'd0, req_ready}, 32'd1);

        for (int i = 0; i < 8; i++) begin
            do_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata);
        end

        // Clear via init_req
        do_access(1'b1, 16'h0000, 8'hFF, 8'h00);
        init_req = 1'b1;
        #1;
        chk("init_ready_low", {31'd0, req_ready}, 32'd0);
        step();
        init_req = 1'b0;
        chk("init_rst_c1", {30'd0, ram_reset, ram_chip_en}, 32'd2);
        step();
        chk("init_rst_c2", {30'd0, ram_reset, init_done}, 32'd2);
        step();
        chk("init_done", {30'd0, ram_reset, init_done}, 32'd1);
        chk("init_done_ready", {31'd0, req_ready}, 32'd1);
        step();
        chk("init_done_pulse", {31'd0, init_done}, 32'd0);
        do_access(1'b0, 16'h0000, 8'h00, 8'h00);

        // init_req and req_valid together: init wins, request accepted with init_done
        req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h1234; req_wdata = 8'h77;
        init_req = 1'b1;
        #1;
        chk("both_ready_low", {31'd0, req_ready}, 32'd0);
        step();
        init_req = 1'b0;
        chk("both_init_c1", {30'd0, ram_reset, req_ready}, 32'd2);
        step();
        chk("both_init_c2", {30'd0, ram_reset, req_ready}, 32'd2);
        step();
        chk("both_done_ready", {30'd0, init_done, req_ready}, 32'd3);
        step();
        req_valid = 1'b0;
        chk("both_accepted", {15'd0, ram_chip_en, ram_addr}, {15'd0, 1'b1, 16'h1234});
        wait_cyc = 1;
        while (!rsp_valid && wait_cyc < 20) begin
            step();
            wait_cyc++;
        end
        chk("both_rsp_latency", wait_cyc, 4);
        step();
        do_access(1'b0, 16'h1234, 8'h00, 8'h77);

        // Reset during the strobe of a write
        req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0042; req_wdata = 8'h99;
        step();
        req_valid = 1'b0;
        step();
        chk("abort_in_strobe", {31'd0, ram_wr_en}, 32'd1);
        reset = 1'b1;
        step();
        chk("abort_ram_ctl", {27'd0, ram_chip_en, ram_wr_en, ram_rd_en, ram_reset, rsp_valid}, 32'd0);
        chk("abort_ram_bus", {8'd0, ram_addr, ram_data_in}, 32'd0);
        reset = 1'b0;
        #1;
        chk("abort_ready", {31'd0, req_ready}, 32'd1);
        wait_cyc = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (rsp_valid) wait_cyc++;
        end
        chk("abort_no_rsp", wait_cyc, 0);

        // Back-to-back reads of 0xFFFF then 0x0000 with req_valid held
        do_access(1'b1, 16'hFFFF, 8'hC3, 8'h00);
        do_access(1'b1, 16'h0000, 8'h5E, 8'h00);
        n_acc = 0; n_rsp = 0; cyc = 0;
        acc_cyc[0] = 0; acc_cyc[1] = 0; rsp_d[0] = '0; rsp_d[1] = '0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'hFFFF;
        while (n_rsp < 2 && cyc < 40) begin
            if (rsp_valid) begin
                rsp_d[n_rsp] = rsp_rdata;
                n_rsp++;
            end
            if (req_valid && req_ready && n_acc < 2) begin
                acc_cyc[n_acc] = cyc;
                n_acc++;
            end
            step();
            cyc++;
            if (n_acc == 1) req_addr = 16'h0000;
            else if (n_acc == 2) req_valid = 1'b0;
        end
        chk("b2b_rsp_count", n_rsp, 2);
        chk("b2b_spacing", acc_cyc[1] - acc_cyc[0], 5);
        chk("b2b_rdata_ffff", {24'd0, rsp_d[0]}, 32'hC3);
        chk("b2b_rdata_0000", {24'd0, rsp_d[1]}, 32'h5E);
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
